oc_stream_rr_arbiter: RTL and testbench

Round-robin arbiter that merges Inputs valid/ready streams into one registered output stream. Typical use: several ocsim_data_source instances, or RTL producers, feeding a single consumer port in block benches and in the real datapath. It supports a configurable burst lock, so one requester can hold the output for up to MaxBurst consecutive beats. A per-input enable mask lets software or the bench exclude requesters at runtime.

---
 rtl/oc_arb_pkg.sv | 39 +++
 rtl/oc_stream_rr_arbiter_pick.sv | 30 +++
 rtl/oc_stream_rr_arbiter.sv | 107 ++++++++++
 tb/tb_oc_stream_rr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/oc_arb_pkg.sv
// Shared types and helpers for the oc stream arbiters.
package oc_arb_pkg;

  // Arbiter control state: free search or burst lock held by lastGrant.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  localparam int MaxInputs   = 16;
  localparam int MaxSelWidth = 4;

  typedef struct packed {
    logic                   found;
    logic [MaxSelWidth-1:0] index;
  } pick_t;

  // Rotating priority search: first set bit of req strictly after lastGrant,
  // wrapping modulo inputs, so lastGrant itself is considered last.
  function automatic pick_t RoundRobinPick(input logic [MaxInputs-1:0]   req,
                                           input logic [MaxSelWidth-1:0] lastGrant,
                                           input int                     inputs);
    pick_t result;
    int    idx;
    result = '0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = MaxInputs; k >= 1; k--) begin
      if (k <= inputs) begin
        idx = (int'(lastGrant) + k) % inputs;
        if (req[idx[MaxSelWidth-1:0]]) begin
          result.found = 1'b1;
          result.index = idx[MaxSelWidth-1:0];
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/oc_stream_rr_arbiter_pick.sv
// Combinational priority rotator: request vector plus last grant in,
// next grant index and found flag out.
module oc_rr_pick
  import oc_arb_pkg::*;
#(
  parameter  int Inputs   = 4,
  localparam int SelWidth = $clog2(Inputs)
) (
  input  logic [Inputs-1:0]   req,
  input  logic [SelWidth-1:0] lastGrant,
  output logic [SelWidth-1:0] grant,
  output logic                found
);

  logic [MaxInputs-1:0]   reqWide;
  logic [MaxSelWidth-1:0] lastWide;
  pick_t                  pick;

  // Widen to the package helper's fixed size and narrow the result back.
  always_comb begin
    reqWide                 = '0;
    reqWide[Inputs-1:0]     = req;
    lastWide                = '0;
    lastWide[SelWidth-1:0]  = lastGrant;
    pick                    = RoundRobinPick(reqWide, lastWide, Inputs);
    grant                   = pick.index[SelWidth-1:0];
    found                   = pick.found;
  end

endmodule

// File: rtl/oc_stream_rr_arbiter.sv
// Round-robin merge of several valid/ready streams into one registered
// output stream, with an optional burst lock of up to MaxBurst beats.
module oc_stream_rr_arbiter
  import oc_arb_pkg::*;
#(
  parameter  type Type     = logic [31:0],
  parameter  int  Inputs   = 4,
  parameter  int  MaxBurst = 1,
  localparam int  SelWidth = $clog2(Inputs)
) (
  input  logic                clock,
  input  logic                reset,
  input  Type                 inData [Inputs],
  input  logic [Inputs-1:0]   inValid,
  output logic [Inputs-1:0]   inReady,
  input  logic [Inputs-1:0]   inEnable,
  output Type                 outData,
  output logic                outValid,
  input  logic                outReady,
  output logic [SelWidth-1:0] outSource,
  output logic                burstActive
);

  localparam logic [7:0] BurstLimit = 8'(MaxBurst);
  localparam arbState_t  GrantState = (MaxBurst > 1) ? LOCKED : IDLE;

  arbState_t           state, stateNext;
  logic [SelWidth-1:0] lastGrant, lastGrantNext;
  logic [SelWidth-1:0] grant, pickIdx;
  logic [7:0]          burstCount, burstCountNext;
  logic [Inputs-1:0]   req;
  logic                load, grantValid, pickFound, keepLock;

  oc_rr_pick #(.Inputs(Inputs)) picker (
    .req       (req),
    .lastGrant (lastGrant),
    .grant     (pickIdx),
    .found     (pickFound)
  );

  // Grant decision: continue a live burst, otherwise rotate from lastGrant+1.
  always_comb begin
    load           = !outValid || outReady;
    req            = inValid & inEnable;
    keepLock       = (state == LOCKED) && req[lastGrant] && (burstCount < BurstLimit);
    grantValid     = 1'b0;
    grant          = lastGrant;
    lastGrantNext  = lastGrant;
    burstCountNext = burstCount;
    stateNext      = state;
    // No handshakes are offered while reset is held.
    if (reset && load) begin
      if (keepLock) begin
        grantValid     = 1'b1;
        burstCountNext = burstCount + 8'd1;
      end else if (pickFound) begin
        grantValid     = 1'b1;
        grant          = pickIdx;
        lastGrantNext  = pickIdx;
        burstCountNext = 8'd1;
        stateNext      = GrantState;
      end else begin
        stateNext      = IDLE;
      end
    end
  end

  // One-hot ready to the granted requester only.
  always_comb begin
    inReady = '0;
    for (int i = 0; i < Inputs; i++) begin
      inReady[i] = grantValid && (grant == SelWidth'(i));
    end
  end

  // Output register stage and arbitration state; everything holds under stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lastGrant  <= SelWidth'(Inputs - 1);
      burstCount <= '0;
      outValid   <= 1'b0;
      outData    <= '0;
      outSource  <= '0;
    end else if (load) begin
      state      <= stateNext;
      lastGrant  <= lastGrantNext;
      burstCount <= burstCountNext;
      outValid   <= grantValid;
      if (grantValid) begin
        outData   <= inData[grant];
        outSource <= grant;
      end
    end
  end

  assign burstActive = (state == LOCKED);

  // Handshake sanity checks for simulation.
  inReadyOneHot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(inReady));
  inReadyEnabledOnly: assert property (@(posedge clock) disable iff (!reset)
    (inReady & ~inEnable) == '0);
  outStableOnStall: assert property (@(posedge clock) disable iff (!reset)
    (outValid && !outReady) |=> ($stable(outData) && $stable(outSource)));

endmodule

// File: tb/tb_oc_stream_rr_arbiter.sv
// Bench for oc_stream_rr_arbiter: two instances (MaxBurst 1 and 3) share
// stimulus and are compared against a beat-level reference model.
module tb_oc_stream_rr_arbiter;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   inData [N];
  logic [N-1:0]  inValid, inEnable;
  logic          outReady;

  logic [N-1:0]  inReadyQ   [2];
  logic [31:0]   outDataQ   [2];
  logic          outValidQ  [2];
  logic [1:0]    outSourceQ [2];
  logic          burstQ     [2];

  int checks = 0;
  int fails  = 0;

  // Reference model: per instance, the held output beat plus burst ownership.
  int          mLast  [2];
  int          mBeats [2];
  bit          mLocked[2];
  bit          mValid [2];
  logic [31:0] mData  [2];
  int          mSrc   [2];
  int          mGrant [2];
  bit          mCont  [2];

  always #5 clock = ~clock;

  oc_stream_rr_arbiter #(.Type(logic [31:0]), .Inputs(N), .MaxBurst(1)) dut1 (
    .clock(clock), .reset(reset), .inData(inData), .inValid(inValid),
    .inReady(inReadyQ[0]), .inEnable(inEnable), .outData(outDataQ[0]),
    .outValid(outValidQ[0]), .outReady(outReady), .outSource(outSourceQ[0]),
    .burstActive(burstQ[0]));

  oc_stream_rr_arbiter #(.Type(logic [31:0]), .Inputs(N), .MaxBurst(3)) dut3 (
    .clock(clock), .reset(reset), .inData(inData), .inValid(inValid),
    .inReady(inReadyQ[1]), .inEnable(inEnable), .outData(outDataQ[1]),
    .outValid(outValidQ[1]), .outReady(outReady), .outSource(outSourceQ[1]),
    .burstActive(burstQ[1]));

  function automatic int maxBurst(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mLast[k] = N - 1; mBeats[k] = 0; mLocked[k] = 0;
      mValid[k] = 0; mData[k] = '0; mSrc[k] = 0;
    end
  endtask

  // Who gets the beat this cycle, from the rules: a live burst continues while
  // its owner still requests and has beats left; otherwise the nearest
  // requester after the previous owner wins.
  task automatic decide();
    logic [N-1:0] req;
    req = inValid & inEnable;
    for (int k = 0; k < 2; k++) begin
      mGrant[k] = -1;
      mCont[k]  = 0;
      if (reset && (!mValid[k] || outReady)) begin
        if (mLocked[k] && req[mLast[k]] && mBeats[k] < maxBurst(k)) begin
          mGrant[k] = mLast[k];
          mCont[k]  = 1;
        end else begin
          for (int d = 1; d <= N; d++)
            if (mGrant[k] < 0 && req[(mLast[k] + d) % N]) mGrant[k] = (mLast[k] + d) % N;
        end
      end
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (!mValid[k] || outReady) begin
        if (mGrant[k] >= 0) begin
          mValid[k] = 1;
          mData[k]  = inData[mGrant[k]];
          mSrc[k]   = mGrant[k];
          if (mCont[k]) mBeats[k]++;
          else begin mBeats[k] = 1; mLast[k] = mGrant[k]; end
          mLocked[k] = (maxBurst(k) > 1);
        end else begin
          mValid[k]  = 0;
          mLocked[k] = 0;
        end
      end
    end
  endtask

  task automatic randData();
    for (int i = 0; i < N; i++) inData[i] = $urandom;
  endtask

  // One clock: check ready mid-cycle, advance model, check registered outputs.
  task automatic step();
    logic [N-1:0] expRdy;
    @(negedge clock);
    decide();
    for (int k = 0; k < 2; k++) begin
      expRdy = (mGrant[k] >= 0) ? N'(1 << mGrant[k]) : '0;
      check($sformatf("inReady_dut%0d", k), 64'(inReadyQ[k]), 64'(expRdy));
    end
    commit();
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("outValid_dut%0d", k),    64'(outValidQ[k]),  64'(mValid[k]));
      check($sformatf("outSource_dut%0d", k),   64'(outSourceQ[k]), 64'(mSrc[k]));
      check($sformatf("outData_dut%0d", k),     64'(outDataQ[k]),   64'(mData[k]));
      check($sformatf("burstActive_dut%0d", k), 64'(burstQ[k]),     64'(mLocked[k]));
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_outValid_dut%0d", tag, k),  64'(outValidQ[k]),  64'(0));
      check($sformatf("%s_outSource_dut%0d", tag, k), 64'(outSourceQ[k]), 64'(0));
      check($sformatf("%s_outData_dut%0d", tag, k),   64'(outDataQ[k]),   64'(0));
      check($sformatf("%s_burst_dut%0d", tag, k),     64'(burstQ[k]),     64'(0));
      check($sformatf("%s_inReady_dut%0d", tag, k),   64'(inReadyQ[k]),   64'(0));
    end
  endtask

  initial begin
    bit found;
    reset = 1'b0; inValid = '0; inEnable = '0; outReady = 1'b0;
    for (int i = 0; i < N; i++) inData[i] = '0;
    modelReset();

    // Reset state, then release between edges with no requests pending.
    #3;
    checkResetState("reset");
    #9 reset = 1'b1;
    @(posedge clock);
    #1;

    // Everybody valid: pure rotation on dut1, bursts of three on dut3.
    inValid = '1; inEnable = '1; outReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randData();
      step();
      check($sformatf("seqRR_%0d", i),    64'(outSourceQ[0]), 64'(i % 4));
      check($sformatf("seqBurst_%0d", i), 64'(outSourceQ[1]), 64'((i / 3) % 4));
      check($sformatf("burstHeld_%0d", i), 64'(burstQ[1]), 64'(1));
    end

    // dut3 starts a burst on 0; input 0 then drops and 1 follows with no bubble.
    randData(); step();
    inValid = 4'b1110;
    randData(); step();
    check("dropNoBubble_valid", 64'(outValidQ[1]), 64'(1));
    check("dropNoBubble_src",   64'(outSourceQ[1]), 64'(1));
    inValid = '1;

    // Second beat on 1, then five stalled cycles, then the third beat and rotate.
    randData(); step();
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randData(); step();
      check($sformatf("stallSrc_%0d", i), 64'(outSourceQ[1]), 64'(1));
    end
    outReady = 1'b1;
    randData(); step();
    check("resumeSameSrc", 64'(outSourceQ[1]), 64'(1));
    randData(); step();
    check("resumeRotate", 64'(outSourceQ[1]), 64'(2));

    // Only inputs 1 and 3 enabled; drop 3 while its burst has just started.
    inEnable = 4'b1010;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      randData(); step();
      if (mSrc[1] == 3 && mBeats[1] == 1 && mLocked[1]) found = 1;
    end
    check("lockOn3Reached", 64'(found), 64'(1));
    inEnable = 4'b0010;
    randData(); step();
    check("disableRelease_src", 64'(outSourceQ[1]), 64'(1));

    // Nothing enabled: output drains.
    inEnable = '0;
    randData(); step();
    randData(); step();
    check("drain_dut1", 64'(outValidQ[0]), 64'(0));
    check("drain_dut3", 64'(outValidQ[1]), 64'(0));

    // Random traffic, masks and back-pressure.
    for (int i = 0; i < 400; i++) begin
      inValid  = N'($urandom);
      inEnable = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      outReady = ($urandom_range(0, 3) != 0);
      randData();
      step();
    end

    // Asynchronous reset in the middle of a burst.
    inValid = '1; inEnable = '1; outReady = 1'b1;
    randData(); step();
    randData(); step();
    #2 reset = 1'b0;
    #1;
    checkResetState("asyncReset");
    modelReset();
    reset = 1'b1;
    randData(); step();
    check("afterReset_src1", 64'(outSourceQ[0]), 64'(0));
    check("afterReset_src3", 64'(outSourceQ[1]), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
